// File: rtl/regfile_wbuf_pkg.sv
// Shared constants, payload type and address qualification helper for regfile_wbuf.
package regfile_wbuf_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    // Buffered write payload at the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } pend_t;

    // An address maps to a real, non-hardwired register.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned nreg,
                                        input int unsigned zero_reg);
        return (addr < nreg) && !((zero_reg != 0) && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_wbuf_read_mux.sv
// One read port: range/zero-register masking, buffered-write bypass, array select.
module regfile_read_mux
    import regfile_wbuf_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NREG     = 8,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic [DATA_W-1:0] pend_data,
    input  logic [DATA_W-1:0] regs [NREG],
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = '0;
        if (!addr_valid(32'(rd_addr), NREG, ZERO_REG)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && pend_valid && (rd_addr == pend_addr)) begin
            rd_data = pend_data;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/regfile_wbuf.sv
// Register file with a one-entry write buffer: writes are accepted on one edge
// and committed to the array on the next, with optional read forwarding.
module regfile_wbuf
    import regfile_wbuf_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NREG     = 8,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [NREG-1:0]   commit_onehot,
    output logic              pend_valid
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_t;

    wbuf_t             pend;
    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok_c;

    assign wr_ok_c = wr_en && addr_valid(32'(wr_addr), NREG, ZERO_REG);

    // Buffer stage: commits the held write and reloads on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid    <= 1'b0;
            pend          <= '0;
            commit_onehot <= '0;
        end else begin
            pend_valid <= wr_ok_c;
            if (wr_ok_c) pend <= '{addr: wr_addr, data: wr_data};
            commit_onehot <= pend_valid ? (NREG'(1) << pend.addr) : '0;
        end
    end

    // Storage array, written only from the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (pend_valid && (pend.addr == ADDR_W'(i))) regs[i] <= pend.data;
            end
        end
    end

    regfile_read_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_a (
        .rd_addr    (rd_addr_a),
        .pend_valid (pend_valid),
        .pend_addr  (pend.addr),
        .pend_data  (pend.data),
        .regs       (regs),
        .rd_data    (rd_data_a)
    );

    regfile_read_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_b (
        .rd_addr    (rd_addr_b),
        .pend_valid (pend_valid),
        .pend_addr  (pend.addr),
        .pend_data  (pend.data),
        .regs       (regs),
        .rd_data    (rd_data_b)
    );

endmodule

// File: tb/tb_regfile_wbuf.sv
// Drives three configurations of regfile_wbuf with one shared stimulus stream and
// checks them against a write-history model of the register file.
module tb_regfile_wbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        pv  [3];
    logic [7:0]  co0;
    logic [7:0]  co1;
    logic [5:0]  co2;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    // cfg0: NREG=8 bypass; cfg1: NREG=8 no bypass; cfg2: NREG=6 zero-reg bypass
    int unsigned nreg [3] = '{8, 8, 6};
    int unsigned zr   [3] = '{0, 0, 1};
    int unsigned byp  [3] = '{1, 0, 1};

    typedef struct {
        int          ed;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t hist [$];
    int  n = 0;

    always #5 clk = ~clk;

    regfile_wbuf #(.DATA_W(16), .ADDR_W(3), .NREG(8), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]),
        .commit_onehot(co0), .pend_valid(pv[0]));

    regfile_wbuf #(.DATA_W(16), .ADDR_W(3), .NREG(8), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]),
        .commit_onehot(co1), .pend_valid(pv[1]));

    regfile_wbuf #(.DATA_W(16), .ADDR_W(3), .NREG(6), .ZERO_REG(1), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]),
        .commit_onehot(co2), .pend_valid(pv[2]));

    function automatic logic writable(input int c, input logic [2:0] a);
        return (32'(a) < nreg[c]) && !((zr[c] != 0) && (a == 3'd0));
    endfunction

    // Latest write to a visible by now: bypass sees writes accepted up to the
    // current edge, otherwise only those accepted at least one edge earlier.
    function automatic logic [15:0] model_rd(input int c, input logic [2:0] a);
        int lim;
        if (!writable(c, a)) return 16'h0;
        lim = (byp[c] != 0) ? n : n - 1;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].ed <= lim && hist[i].addr == a) return hist[i].data;
        end
        return 16'h0;
    endfunction

    function automatic logic model_pv(input int c);
        foreach (hist[i]) if (hist[i].ed == n && writable(c, hist[i].addr)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_co(input int c);
        foreach (hist[i])
            if (hist[i].ed == n - 1 && writable(c, hist[i].addr)) return 32'd1 << hist[i].addr;
        return 32'd0;
    endfunction

    function automatic logic [31:0] dut_co(input int c);
        case (c)
            0:       return {24'd0, co0};
            1:       return {24'd0, co1};
            default: return {26'd0, co2};
        endcase
    endfunction

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            mis_cnt++;
            $error("FAIL %s cfg%0d t=%0t observed=%h expected=%h", tag, c, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            chk("rd_a", c, {16'd0, rda[c]}, {16'd0, model_rd(c, rd_addr_a)});
            chk("rd_b", c, {16'd0, rdb[c]}, {16'd0, model_rd(c, rd_addr_b)});
            chk("pend_valid", c, {31'd0, pv[c]}, {31'd0, model_pv(c)});
            chk("commit_onehot", c, dut_co(c), model_co(c));
        end
    endtask

    // Apply inputs, check pre-edge state, take one edge and record the request.
    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
        #1;
        check_all();
        @(posedge clk);
        n++;
        if (we) hist.push_back('{ed: n, addr: wa, data: wd});
        #1;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        hist.delete();
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("reset_pend", c, {31'd0, pv[c]}, 32'd0);
            chk("reset_commit", c, dut_co(c), 32'd0);
        end

        // Reset with a write in flight
        step(1'b1, 3'd3, 16'h00AA, 3'd3, 3'd3);
        pulse_rst();
        chk("rst_mid_pend", 0, {31'd0, pv[0]}, 32'd0);
        chk("rst_mid_rd3", 0, {16'd0, rda[0]}, 32'd0);
        step(1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
        chk("rst_mid_nocommit", 0, dut_co(0), 32'd0);

        // Basic write/read with bypass
        step(1'b1, 3'd5, 16'h1234, 3'd5, 3'd5);
        chk("byp_after_n", 0, {16'd0, rda[0]}, 32'h1234);
        chk("nobyp_after_n", 1, {16'd0, rdb[1]}, 32'h0);
        step(1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        chk("commit_5", 0, dut_co(0), 32'h20);
        chk("nobyp_after_n1", 1, {16'd0, rdb[1]}, 32'h1234);
        step(1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        chk("commit_5_single", 0, dut_co(0), 32'h0);

        // Back-to-back writes to one address
        step(1'b1, 3'd2, 16'h0001, 3'd2, 3'd2);
        step(1'b1, 3'd2, 16'h0002, 3'd2, 3'd2);
        chk("b2b_commit1", 0, dut_co(0), 32'h04);
        chk("b2b_byp", 0, {16'd0, rda[0]}, 32'h0002);
        step(1'b0, 3'd0, 16'h0, 3'd2, 3'd2);
        chk("b2b_commit2", 0, dut_co(0), 32'h04);
        chk("b2b_final", 0, {16'd0, rda[0]}, 32'h0002);

        // No-bypass visibility
        step(1'b1, 3'd1, 16'hBEEF, 3'd1, 3'd1);
        chk("nobyp_old", 1, {16'd0, rdb[1]}, 32'h0);
        step(1'b0, 3'd0, 16'h0, 3'd1, 3'd1);
        chk("nobyp_new", 1, {16'd0, rdb[1]}, 32'hBEEF);

        // Non-writable addresses on the zero-register, 6-entry instance
        step(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd7);
        chk("drop0_pend", 2, {31'd0, pv[2]}, 32'd0);
        step(1'b1, 3'd7, 16'h5555, 3'd0, 3'd7);
        chk("drop7_pend", 2, {31'd0, pv[2]}, 32'd0);
        chk("drop_nocommit", 2, dut_co(2), 32'd0);
        chk("drop_rd0", 2, {16'd0, rda[2]}, 32'd0);
        chk("drop_rd7", 2, {16'd0, rdb[2]}, 32'd0);

        // Dual read of a register while it commits
        step(1'b1, 3'd4, 16'h0F0F, 3'd4, 3'd4);
        step(1'b0, 3'd0, 16'h0, 3'd4, 3'd4);
        step(1'b0, 3'd0, 16'h0, 3'd4, 3'd4);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom()),
                 3'($urandom_range(7)), 3'($urandom_range(7)));
            if ($urandom_range(49) == 0) pulse_rst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wbuf.md
Name: regfile_wbuf

Overview:
Parametrised register file with a one-entry write buffer, per-register commit strobes and read bypass. It replaces the fixed 8-entry write-select decoder and its external registers with one block: address decode, write qualification, storage, two read ports and write-after-write/read-after-write forwarding. It sits between the datapath writeback stage and operand fetch.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width
NREG, 8, number of implemented registers; must be between 2 and 2**ADDR_W inclusive
ZERO_REG, 0, if 1, register 0 is hardwired to zero and writes to it are discarded
BYPASS, 1, if 1, read ports forward the pending buffered write

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request, sampled on the rising edge
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  DATA_W  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  DATA_W  read port B data (combinational)
commit_onehot  output  NREG  registered one-hot strobe marking the register written at the last edge
pend_valid  output  1  write buffer holds an uncommitted write

Behaviour:
- Reset (asynchronous, active-high): all registers 0, pend_valid 0, buffered address/data 0, commit_onehot 0. An in-flight buffered write is lost. No write commits while rst is high.
- Accept: at edge N, if wr_en=1 and the address is writable, the buffer loads {wr_addr, wr_data} and pend_valid=1 after edge N. Otherwise pend_valid=0 after edge N.
- Writable means wr_addr < NREG, and not (ZERO_REG=1 and wr_addr=0). A non-writable request is dropped silently: buffer not loaded, no strobe, no state change.
- Commit: at edge N+1, if pend_valid=1, the array entry at the buffered address takes the buffered data. commit_onehot = 1<<addr for exactly the cycle after edge N+1, otherwise 0.
- Total write latency is 2 edges to the array and 1 edge to visibility through bypass.
- Back-to-back writes: the buffer commits and reloads on the same edge. There are no stalls, and every accepted write commits exactly once, in order.
- Two consecutive writes to the same address: the second wins. The array holds the first value for one cycle only.
- Read port priority, evaluated in this order:
  1. rd_addr >= NREG returns 0.
  2. ZERO_REG=1 and rd_addr=0 returns 0.
  3. BYPASS=1, pend_valid=1 and rd_addr equals the buffered address returns the buffered data.
  4. Otherwise returns the array entry.
- Same-cycle write input is never forwarded. A read in the cycle of wr_en returns the pre-write value.
- BYPASS=0: a read returns the old value until after the commit edge (edge N+1).
- Both read ports are independent and may use the same address simultaneously.
- commit_onehot has at most one bit set (popcount ≤ 1) at all times.

Decomposition:
- Shared package: constants for address-to-one-hot width helpers, and a pend_t struct {addr, data}. No enums are required.
- One natural sub-module: regfile_read_mux, instantiated twice. It implements the range check, zero-register check, bypass compare and array select.
- Decode and commit logic stay in the top level.

Test Plan:
- Reset mid-operation: write addr 3 = 0x00AA, assert rst between edges N and N+1 -> pend_valid 0 and register 3 reads 0 after release; no commit_onehot pulse.
- Basic write/read, BYPASS=1: write addr 5 = 0x1234 at edge N -> rd_a at addr 5 reads old value 0 before edge N, 0x1234 after edge N (bypass) and after N+1 (array); commit_onehot=0x20 for the single cycle after N+1.
- Back-to-back same address: write addr 2 = 0x0001 at edge N, then 0x0002 at edge N+1 -> commit_onehot=0x04 after N+1 and after N+2; after N+2, port A at addr 2 reads 0x0002; no reader sees 0x0001 after edge N+1.
- BYPASS=0: write addr 1 = 0xBEEF at edge N -> port B reads 0 after N and 0xBEEF only after N+1.
- ZERO_REG=1, NREG=6: write addr 0 = 0xFFFF and addr 7 = 0x5555 -> both dropped, pend_valid stays 0, no strobe; reads of addr 0 and addr 7 return 0.
- Dual read with concurrent commit: port A addr 4 and port B addr 4 while 0x0F0F commits to addr 4 -> both ports return identical values in every cycle.
